// File: rtl/rgb2ycbcr_pkg.sv
// Shared definitions for the RGB to YCbCr stream converter: mode encoding and
// per-mode coefficient table (signed, Q14).
package rgb2ycbcr_pkg;

  typedef enum logic [1:0] {
    BT601  = 2'd0,
    BT709  = 2'd1,
    BYPASS = 2'd2,
    RSVD   = 2'd3
  } mode_t;

  localparam int COEF_FRAC = 14;
  localparam int COEF_W    = 16;

  typedef logic signed [COEF_W-1:0] coef_t;

  // One output channel: three signed weights plus whether the chroma offset applies.
  typedef struct packed {
    coef_t kr;
    coef_t kg;
    coef_t kb;
    logic  off_en;
  } chan_coef_t;

  typedef struct packed {
    chan_coef_t y;
    chan_coef_t cb;
    chan_coef_t cr;
  } mode_coef_t;

  // Bypass is an identity matrix at unity gain, so it shares the datapath and latency.
  localparam mode_coef_t COEF_TABLE [4] = '{
    '{y:  '{kr:  16'sd4899, kg:  16'sd9617, kb:  16'sd1868, off_en: 1'b0},
      cb: '{kr: -16'sd2764, kg: -16'sd5428, kb:  16'sd8192, off_en: 1'b1},
      cr: '{kr:  16'sd8192, kg: -16'sd6860, kb: -16'sd1332, off_en: 1'b1}},
    '{y:  '{kr:  16'sd3483, kg: 16'sd11718, kb:  16'sd1183, off_en: 1'b0},
      cb: '{kr: -16'sd1878, kg: -16'sd6314, kb:  16'sd8192, off_en: 1'b1},
      cr: '{kr:  16'sd8192, kg: -16'sd7442, kb:  -16'sd750, off_en: 1'b1}},
    '{y:  '{kr: 16'sd16384, kg:      16'sd0, kb:      16'sd0, off_en: 1'b0},
      cb: '{kr:     16'sd0, kg:  16'sd16384, kb:      16'sd0, off_en: 1'b0},
      cr: '{kr:     16'sd0, kg:      16'sd0, kb:  16'sd16384, off_en: 1'b0}},
    '{y:  '{kr:  16'sd4899, kg:  16'sd9617, kb:  16'sd1868, off_en: 1'b0},
      cb: '{kr: -16'sd2764, kg: -16'sd5428, kb:  16'sd8192, off_en: 1'b1},
      cr: '{kr:  16'sd8192, kg: -16'sd6860, kb: -16'sd1332, off_en: 1'b1}}
  };

  function automatic mode_t resolve_mode(input logic [1:0] m);
    return (m == RSVD) ? BT601 : mode_t'(m);
  endfunction

endpackage

// File: rtl/rgb2ycbcr_stream_csc_channel.sv
// One colour-space output channel: 3-term signed MAC, optional mid-scale offset,
// half-up rounding and clamp, as three stall-enabled register stages.
module csc_channel
  import rgb2ycbcr_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int FRAC  = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [PIX_W-1:0] r,
  input  logic [PIX_W-1:0] g,
  input  logic [PIX_W-1:0] b,
  input  chan_coef_t       coef,
  output logic [PIX_W-1:0] q
);

  localparam int PROD_W = PIX_W + COEF_W + 1;
  localparam int ACC_W  = PROD_W + 3;
  localparam logic signed [ACC_W-1:0] RND  = ACC_W'(64'sd1 << (FRAC - 1));
  localparam logic signed [ACC_W-1:0] OFS  = ACC_W'(64'sd1 << (PIX_W - 1 + FRAC));
  localparam logic signed [ACC_W-1:0] MAXV = ACC_W'((64'sd1 << PIX_W) - 1);

  logic signed [PIX_W:0]    r_s, g_s, b_s;
  logic signed [PROD_W-1:0] p_r, p_g, p_b;
  logic                     off1;
  logic signed [ACC_W-1:0]  acc, sum_c, sh_c;
  logic [PIX_W-1:0]         q_c;

  assign r_s = $signed({1'b0, r});
  assign g_s = $signed({1'b0, g});
  assign b_s = $signed({1'b0, b});

  always_comb begin
    sum_c = ACC_W'(p_r) + ACC_W'(p_g) + ACC_W'(p_b) + RND;
    if (off1) sum_c = sum_c + OFS;
    sh_c = acc >>> FRAC;
    if (sh_c < 0)         q_c = '0;
    else if (sh_c > MAXV) q_c = '1;
    else                  q_c = sh_c[PIX_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_r  <= '0;
      p_g  <= '0;
      p_b  <= '0;
      off1 <= 1'b0;
      acc  <= '0;
      q    <= '0;
    end else if (en) begin
      p_r  <= PROD_W'(r_s) * PROD_W'(coef.kr);
      p_g  <= PROD_W'(g_s) * PROD_W'(coef.kg);
      p_b  <= PROD_W'(b_s) * PROD_W'(coef.kb);
      off1 <= coef.off_en;
      acc  <= sum_c;
      q    <= q_c;
    end
  end

endmodule

// File: rtl/rgb2ycbcr_stream.sv
// Streaming RGB to YCbCr converter (BT.601 / BT.709 / bypass), 3-cycle pipeline
// with global stall; mode is latched on start-of-frame beats only.
module rgb2ycbcr_stream #(
  parameter int PIX_W     = 8,
  parameter int COEF_FRAC = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [3*PIX_W-1:0] s_data,
  input  logic               s_sof,
  input  logic               s_eol,
  input  logic [1:0]         mode_i,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [3*PIX_W-1:0] m_data,
  output logic               m_sof,
  output logic               m_eol,
  output logic [1:0]         mode_active
);

  import rgb2ycbcr_pkg::*;

  logic       advance, accept;
  logic       v1, v2, v3;
  logic       sof1, sof2, sof3;
  logic       eol1, eol2, eol3;
  mode_t      mode_q, eff_mode;
  mode_coef_t coefs;

  assign advance     = !v3 || m_ready;
  assign s_ready     = advance && !rst;
  assign accept      = s_valid && s_ready;
  assign m_valid     = v3;
  assign m_sof       = sof3;
  assign m_eol       = eol3;
  assign mode_active = mode_q;

  // Coefficients are chosen as the beat enters; from then on the mode lives in the
  // channel's stage registers, so a later switch cannot touch beats in flight.
  always_comb begin
    eff_mode = mode_q;
    if (s_sof) eff_mode = resolve_mode(mode_i);
    coefs = COEF_TABLE[eff_mode];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= BT601;
      v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0;
      sof1 <= 1'b0; sof2 <= 1'b0; sof3 <= 1'b0;
      eol1 <= 1'b0; eol2 <= 1'b0; eol3 <= 1'b0;
    end else begin
      if (accept && s_sof) mode_q <= eff_mode;
      if (advance) begin
        v1   <= accept;
        sof1 <= accept && s_sof;
        eol1 <= accept && s_eol;
        v2   <= v1;
        sof2 <= sof1;
        eol2 <= eol1;
        v3   <= v2;
        sof3 <= sof2;
        eol3 <= eol2;
      end
    end
  end

  csc_channel #(.PIX_W(PIX_W), .FRAC(COEF_FRAC)) u_y (
    .clk(clk), .rst(rst), .en(advance),
    .r(s_data[PIX_W-1:0]), .g(s_data[2*PIX_W-1:PIX_W]), .b(s_data[3*PIX_W-1:2*PIX_W]),
    .coef(coefs.y), .q(m_data[PIX_W-1:0])
  );

  csc_channel #(.PIX_W(PIX_W), .FRAC(COEF_FRAC)) u_cb (
    .clk(clk), .rst(rst), .en(advance),
    .r(s_data[PIX_W-1:0]), .g(s_data[2*PIX_W-1:PIX_W]), .b(s_data[3*PIX_W-1:2*PIX_W]),
    .coef(coefs.cb), .q(m_data[2*PIX_W-1:PIX_W])
  );

  csc_channel #(.PIX_W(PIX_W), .FRAC(COEF_FRAC)) u_cr (
    .clk(clk), .rst(rst), .en(advance),
    .r(s_data[PIX_W-1:0]), .g(s_data[2*PIX_W-1:PIX_W]), .b(s_data[3*PIX_W-1:2*PIX_W]),
    .coef(coefs.cr), .q(m_data[3*PIX_W-1:2*PIX_W])
  );

endmodule

// File: doc/rgb2ycbcr_stream.md
RGB2YCBCR_STREAM -- requirements
Module: rgb2ycbcr_stream

Interface
REQ-001 SHALL have parameter PIX_W, default 8, meaning component width in bits; legal range 8..12.
REQ-002 SHALL have parameter COEF_FRAC, default 14, meaning coefficient fraction bits; only 14 is supported.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port s_valid  input  1  input beat valid.
REQ-006 SHALL have port s_ready  output  1  input beat accepted when s_valid && s_ready.
REQ-007 SHALL have port s_data  input  3*PIX_W  R in [PIX_W-1:0], G in the middle field, B in the top field.
REQ-008 SHALL have port s_sof  input  1  first pixel of frame.
REQ-009 SHALL have port s_eol  input  1  last pixel of line.
REQ-010 SHALL have port mode_i  input  2  requested mode: 0 BT.601, 1 BT.709, 2 bypass, 3 reserved (treated as 0).
REQ-011 SHALL have port m_valid  output  1  output beat valid.
REQ-012 SHALL have port m_ready  input  1  downstream accept.
REQ-013 SHALL have port m_data  output  3*PIX_W  Y low field, Cb middle field, Cr top field.
REQ-014 SHALL have ports m_sof and m_eol  output  1 each  sideband aligned with m_data.
REQ-015 SHALL have port mode_active  output  2  mode currently latched for new input beats.

Function
REQ-016 SHALL compute Y = Ky_r*R + Ky_g*G + Ky_b*B, Cb = off - Kb_r*R - Kb_g*G + Kb_b*B, Cr = off + Kr_r*R - Kr_g*G - Kr_b*B, with off = 2^(PIX_W-1) and coefficients scaled by 2^14.
REQ-017 SHALL use BT.601 coefficients Y 4899/9617/1868, Cb 2764/5428/8192, Cr 8192/6860/1332.
REQ-018 SHALL use BT.709 coefficients Y 3483/11718/1183, Cb 1878/6314/8192, Cr 8192/7442/750.
REQ-019 SHALL keep intermediates signed and wide enough that no overflow occurs for any PIX_W in range.
REQ-020 SHALL round half-up (add 2^13, then shift right 14) and clamp each result to [0, 2^PIX_W-1], at both the low and the high end.
REQ-021 SHALL, in bypass mode, pass s_data to m_data unchanged with identical latency.
REQ-022 SHALL be a 3-stage pipeline: products, then sums, then round/clamp; latency is exactly 3 cycles from acceptance to m_valid when m_ready is held high.
REQ-023 SHALL sustain throughput of 1 beat/clk with no bubbles while m_ready=1.
REQ-024 SHALL use global stall: advance = !m_valid || m_ready; s_ready = advance and !rst; all stages hold when advance=0.
REQ-025 SHALL hold m_data, m_sof and m_eol stable while m_valid && !m_ready.
REQ-026 SHALL never drop, duplicate or reorder beats.
REQ-027 SHALL move empty (valid=0) stages regardless of m_ready, so that bubbles collapse.
REQ-028 SHALL update mode_active from mode_i only on an accepted beat with s_sof=1; that beat and all following beats use the new mode.
REQ-029 SHALL ignore mode_i changes on all other cycles.
REQ-030 SHALL carry the mode per pipeline stage, so a switch does not affect beats already in flight.
REQ-031 SHALL carry s_sof and s_eol through the pipeline with the same latency and stall behaviour as s_data.

Reset
REQ-032 SHALL, on rst, asynchronously clear m_valid, all stage valid bits, m_data, m_sof, m_eol and all pipeline registers to 0, and set mode_active to 0 (BT.601).
REQ-033 SHALL discard all in-flight beats when rst asserts mid-stream; m_valid=0 from the reset edge onward.
REQ-034 SHALL assert s_ready=1 in the first cycle after rst deasserts.

Structure
REQ-035 SHALL place in a shared package rgb2ycbcr_pkg: the mode enum (BT601, BT709, BYPASS, RSVD), COEF_FRAC, and the coefficient table indexed by mode.
REQ-036 SHALL implement one output channel (3-term signed multiply-accumulate, offset, round, clamp, with stall enable) as sub-module csc_channel, instantiated 3 times.

Verification
REQ-037 SHALL cover: BT.601, PIX_W=8, RGB (255,255,255) -> YCbCr (255,128,128); RGB (255,0,0) -> (76,85,255), where Cr clamps from 256.
REQ-038 SHALL cover: BT.709, PIX_W=8, RGB (0,0,255) -> (18,255,116); PIX_W=10, BT.601, RGB (0,0,0) -> (0,512,512).
REQ-039 SHALL cover: 8-pixel stream with m_ready low for 5 cycles mid-stream -> all 8 outputs present, in order, held stable while stalled; s_ready low once the pipeline is full.
REQ-040 SHALL cover: mode_i changed 0->1 mid-frame without s_sof -> outputs stay BT.601; next accepted s_sof beat and later beats are BT.709; mode_active=1 one cycle after that beat.
REQ-041 SHALL cover: mode 2 with s_data 0x123456 -> m_data 0x123456 exactly 3 cycles later; s_sof/s_eol aligned.
REQ-042 SHALL cover: rst pulsed with 3 beats in flight -> m_valid=0 immediately; no stale beat after release; mode_active=0.
